pe_ctx_seq: RTL
===============

// Module: pe_ctx_seq
// PURPOSE
//  Parametrised multi-context processing element for the SC-CGRA array.
//  - Holds CTX_DEPTH context words loaded over a valid/ready config port.
//  - Sequencer steps a context PC every cycle over a programmed loop, for a programmed iteration count.
//  - Each context selects ALU operands from NUM_PORTS input buses or a RF_DEPTH-entry register file.
//  - Drives NUM_PORTS output buses with either the registered ALU result or a chosen RF entry.
// PARAMETERS
//  DATA_W     32  datapath width
//  NUM_PORTS  6   input/output bus count (up, down, left, right, bypass_1, bypass_2 at default)
//  CTX_DEPTH  4   context slots (>=2)
//  RF_DEPTH   4   register file entries (>=2)
//  Local: SEL_W=$clog2(NUM_PORTS+RF_DEPTH), RA_W=$clog2(RF_DEPTH), CA_W=$clog2(CTX_DEPTH)
//  Local: CTX_W=2*SEL_W+4+1+2*RA_W+NUM_PORTS
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  synchronous reset, active-high
//  din        in   NUM_PORTS*DATA_W   input buses, bus i at [i*DATA_W +: DATA_W]
//  dout       out  NUM_PORTS*DATA_W   output buses, same packing
//  cfg_valid  in   1                  context write request
//  cfg_ready  out  1                  high only in IDLE
//  cfg_addr   in   CA_W               context slot to write
//  cfg_data   in   CTX_W              context word
//  start      in   1                  begin run (sampled in IDLE only)
//  ctx_last   in   CA_W               last PC of loop (loop = 0..ctx_last), sampled with start
//  iter       in   16                 loop iterations, sampled with start; 0 is treated as 1
//  busy       out  1                  high in RUN
//  done       out  1                  one-cycle pulse in DONE
// BEHAVIOUR
//  Context word fields, LSB first:
//    srcA[SEL_W], srcB[SEL_W], op[4], rf_we, rf_waddr[RA_W], rf_oaddr[RA_W], osel[NUM_PORTS]
//  Operand source selection:
//    index < NUM_PORTS selects din bus index.
//    index < NUM_PORTS+RF_DEPTH selects RF[index-NUM_PORTS].
//    any other index reads 0.
//  ALU ops (results wrap mod 2^DATA_W):
//    0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL A by B[4:0], 6 SHR logical, 7 MUL low DATA_W, 8 PASS A.
//    9-15 produce 0.
//  Reset: all of the following are cleared, and dout=0, cfg_ready=1:
//    context memory, RF, alu_res_reg, PC, iteration counter, busy, done; state IDLE.
//  FSM IDLE:
//    cfg_valid&cfg_ready writes ctx[cfg_addr] at the edge.
//    start -> RUN with PC=0, itc=max(iter,1).
//    A same-cycle write and start both take effect.
//  FSM RUN:
//    Per cycle, the active context is ctx[PC].
//    At the edge: alu_res_reg<=ALU; if rf_we then RF[rf_waddr]<=ALU (combinational result, same edge).
//    At PC==ctx_last: PC<=0 and itc<=itc-1; if itc==1, go to DONE instead.
//    Otherwise PC<=PC+1.
//    start and cfg_valid are ignored.
//  FSM DONE: done=1 for one cycle, then IDLE. PC returns to 0; RF and alu_res_reg hold.
//  Outputs: dout[i] = osel[i] ? alu_res_reg : RF[rf_oaddr], using ctx[PC]; holds in IDLE/DONE.
//  Latency: operand to alu_res_reg is 1 cycle. RF write to RF-sourced operand is 1 cycle (no bypass).
//  Reset mid-RUN aborts immediately: IDLE, no done pulse, contexts cleared.
//  ctx_last >= CTX_DEPTH is clamped to CTX_DEPTH-1.
// CONFIGURATION
//  PE_CTX_SAT_EN:
//    defined: ops 0/1 become signed saturating add/sub, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//    undefined: wrap-around as above. No port change.
// TESTING
//  T1 reset:
//    rst for 2 cycles -> dout=0, cfg_ready=1, busy=0, done=0.
//    No RF or ctx write occurs while rst is high.
//  T2 single ADD:
//    ctx0 = A=din0, B=din1, ADD, osel all 1; din0=5, din1=7; start with ctx_last=0, iter=1.
//    -> busy for 1 cycle, then all dout=12, done pulse 1 cycle later.
//  T3 loop/accumulate:
//    ctx0: RF0 <= RF0 + din2 (rf_we=1); din2=3; iter=4, ctx_last=0.
//    -> RF0 = 12; dout (osel=0, oaddr=0) shows 12 after DONE.
//  T4 multi-context wrap:
//    ctx0 = PASS din0; ctx1 = SUB din0-din1; din0=1, din1=2; ctx_last=1, iter=2.
//    -> PC sequence 0,1,0,1.
//    -> alu_res_reg = 1, 0xFFFFFFFF, 1, 0xFFFFFFFF (0x80000000-saturation N/A).
//    -> done asserts on the 5th cycle after start.
//  T5 handshake:
//    cfg_valid during RUN -> cfg_ready=0 and the write is dropped.
//    start during RUN is ignored.
//    Write plus start in the same IDLE cycle -> the new ctx0 is used at PC=0.
//  T6 SAT_EN:
//    ADD 0x7FFFFFFF + 1 -> 0x7FFFFFFF with PE_CTX_SAT_EN; 0x80000000 without.
//    Reset asserted mid-RUN -> no done pulse.

Source files
------------

// File: rtl/pe_ctx_seq.sv
// pe_ctx_seq: multi-context CGRA processing element with a looping context sequencer.
// Build option PE_CTX_SAT_EN: ops 0/1 become signed saturating ADD/SUB (no port change).
module pe_ctx_seq #(
    parameter int DATA_W    = 32,
    parameter int NUM_PORTS = 6,
    parameter int CTX_DEPTH = 4,
    parameter int RF_DEPTH  = 4,
    localparam int SEL_W = $clog2(NUM_PORTS + RF_DEPTH),
    localparam int RA_W  = $clog2(RF_DEPTH),
    localparam int CA_W  = $clog2(CTX_DEPTH),
    localparam int CTX_W = 2*SEL_W + 4 + 1 + 2*RA_W + NUM_PORTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*DATA_W-1:0]   din,
    output logic [NUM_PORTS*DATA_W-1:0]   dout,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CA_W-1:0]               cfg_addr,
    input  logic [CTX_W-1:0]              cfg_data,
    input  logic                          start,
    input  logic [CA_W-1:0]               ctx_last,
    input  logic [15:0]                   iter,
    output logic                          busy,
    output logic                          done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int LW = CA_W + 1;
    localparam logic [LW-1:0] LAST_MAX = LW'(CTX_DEPTH - 1);

    state_t state_q, state_d;
    logic [CTX_W-1:0]  ctx_q [CTX_DEPTH];
    logic [CTX_W-1:0]  ctx_d [CTX_DEPTH];
    logic [DATA_W-1:0] rf_q [RF_DEPTH];
    logic [DATA_W-1:0] rf_d [RF_DEPTH];
    logic [DATA_W-1:0] alu_res_q, alu_res_d;
    logic [CA_W-1:0]   pc_q, pc_d, last_q, last_d;
    logic [15:0]       itc_q, itc_d;
    logic [SEL_W-1:0]  src_a, src_b;
    logic [3:0]        op;
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr, rf_oaddr;
    logic [NUM_PORTS-1:0] osel;
    logic [DATA_W-1:0] opa, opb, alu, add_r, sub_r;
    logic              at_last;

    assign {osel, rf_oaddr, rf_waddr, rf_we, op, src_b, src_a} = ctx_q[pc_q];
    assign at_last = pc_q == last_q;

    // Operand muxes: input buses first, then RF entries, anything beyond reads zero
    always_comb begin
        opa = '0;
        opb = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (src_a == SEL_W'(i)) opa = din[i*DATA_W +: DATA_W];
            if (src_b == SEL_W'(i)) opb = din[i*DATA_W +: DATA_W];
        end
        for (int i = 0; i < RF_DEPTH; i++) begin
            if (src_a == SEL_W'(NUM_PORTS + i)) opa = rf_q[i];
            if (src_b == SEL_W'(NUM_PORTS + i)) opb = rf_q[i];
        end
    end

`ifdef PE_CTX_SAT_EN
    logic [DATA_W:0] add_x, sub_x;
    assign add_x = {opa[DATA_W-1], opa} + {opb[DATA_W-1], opb};
    assign sub_x = {opa[DATA_W-1], opa} - {opb[DATA_W-1], opb};
    assign add_r = add_x[DATA_W] != add_x[DATA_W-1] ? {add_x[DATA_W], {(DATA_W-1){~add_x[DATA_W]}}} : add_x[DATA_W-1:0];
    assign sub_r = sub_x[DATA_W] != sub_x[DATA_W-1] ? {sub_x[DATA_W], {(DATA_W-1){~sub_x[DATA_W]}}} : sub_x[DATA_W-1:0];
`else
    assign add_r = opa + opb;
    assign sub_r = opa - opb;
`endif

    // ALU for the active context
    always_comb begin
        case (op)
            4'd0: alu = add_r;
            4'd1: alu = sub_r;
            4'd2: alu = opa & opb;
            4'd3: alu = opa | opb;
            4'd4: alu = opa ^ opb;
            4'd5: alu = opa << opb[4:0];
            4'd6: alu = opa >> opb[4:0];
            4'd7: alu = opa * opb;
            4'd8: alu = opa;
            default: alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Next state: run ends on the last PC of the final iteration
    always_comb begin
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = at_last && itc_q == 16'd1 ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        cfg_ready = state_q == IDLE;
        busy = state_q == RUN;
        done = state_q == DONE;
    end

    // Context writes, run setup, PC/iteration stepping and RF/result updates
    always_comb begin
        ctx_d = ctx_q;
        rf_d = rf_q;
        alu_res_d = alu_res_q;
        pc_d = pc_q;
        itc_d = itc_q;
        last_d = last_q;
        if (state_q == IDLE) begin
            if (cfg_valid) ctx_d[cfg_addr] = cfg_data;
            if (start) begin
                pc_d = '0;
                itc_d = iter == 16'd0 ? 16'd1 : iter;
                last_d = {1'b0, ctx_last} > LAST_MAX ? LAST_MAX[CA_W-1:0] : ctx_last;
            end
        end else if (state_q == RUN) begin
            alu_res_d = alu;
            if (rf_we) rf_d[rf_waddr] = alu;
            pc_d = at_last ? '0 : pc_q + CA_W'(1);
            if (at_last) itc_d = itc_q - 16'd1;
        end else begin
            pc_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctx_q <= '{default: '0};
            rf_q <= '{default: '0};
            alu_res_q <= '0;
            pc_q <= '0;
            itc_q <= '0;
            last_q <= '0;
        end else begin
            ctx_q <= ctx_d;
            rf_q <= rf_d;
            alu_res_q <= alu_res_d;
            pc_q <= pc_d;
            itc_q <= itc_d;
            last_q <= last_d;
        end
    end

    // Output buses: registered result or selected RF entry, per port
    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_PORTS; i++) dout[i*DATA_W +: DATA_W] = osel[i] ? alu_res_q : rf_q[rf_oaddr];
    end
endmodule
